// File: rtl/aes_word_loader.sv
// Word loader and result capture around the AES encrypt core.
// Latency: Nr+2 clk edges from the last-word handshake to out_valid.
// Backpressure: in_ready drops for the whole run; out_ready low holds the result indefinitely.
module aes_word_loader #(
    parameter int N  = 128,  // key width in bits, must match the core
    parameter int Nr = 10,   // round count, must match the core
    parameter int Nk = 4     // key words (N/32)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] core_datain,
    output logic [N-1:0] core_key,
    output logic         core_rst,
    input  logic [127:0] core_state,
    output logic [127:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    // Words per block: four plaintext words followed by Nk key words.
    localparam int W   = 4 + Nk;
    localparam int WCW = $clog2(W);
    localparam int CCW = $clog2(Nr + 2);

    localparam logic [WCW-1:0] WLAST = WCW'(W - 1);
    localparam logic [WCW-1:0] WKEY0 = WCW'(4);
    // The core's ciphertext is valid after its (Nr+1)th edge out of reset,
    // so it is sampled on the edge where ccnt has reached Nr+1.
    localparam logic [CCW-1:0] CLAST = CCW'(Nr + 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        RUN     = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [WCW-1:0] wcnt;
    logic [CCW-1:0] ccnt;
    logic           accept;
    logic           last_word;
    logic           capture;
    logic           handoff;

    assign in_ready = (state == COLLECT);
    assign busy     = (state != COLLECT);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and the per-cycle strobes that drive the datapath.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_word = 1'b0;
        capture   = 1'b0;
        handoff   = 1'b0;
        case (state)
            COLLECT: begin
                accept = in_valid;
                if (in_valid && (wcnt == WLAST)) begin
                    last_word = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (ccnt == CLAST) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    handoff   = 1'b1;
                    state_nxt = COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    // Word buffers, counters, core reset control and result register.
    // Buffers shift left with the newest word at the LSB, so the first
    // word of each group ends up in the most significant position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt        <= '0;
            ccnt        <= '0;
            core_datain <= '0;
            core_key    <= '0;
            core_rst    <= 1'b1;
            out_data    <= '0;
            out_valid   <= 1'b0;
        end else begin
            if (accept) begin
                if (wcnt < WKEY0) begin
                    core_datain <= {core_datain[95:0], in_data};
                end else begin
                    core_key <= {core_key[N-33:0], in_data};
                end
                wcnt <= last_word ? '0 : wcnt + WCW'(1);
            end

            if (last_word) begin
                ccnt     <= '0;
                core_rst <= 1'b0;
            end else if (state == RUN) begin
                ccnt <= ccnt + CCW'(1);
            end

            if (capture) begin
                out_data  <= core_state;
                out_valid <= 1'b1;
                core_rst  <= 1'b1;
            end

            if (handoff) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
